// File: rtl/uart_hex_framer_pkg.sv
// Shared types and ASCII constants for the UART hex framer.
// FSM state encoding plus the character codes used by the nibble converter and CR/LF tail.
package uart_hex_framer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_HI,
      WAIT_LO,
      FINISH
   } state_t;

   localparam logic [7:0] ASCII_0      = 8'h30;
   localparam logic [7:0] ASCII_CR     = 8'h0D;
   localparam logic [7:0] ASCII_LF     = 8'h0A;
   localparam logic [7:0] ASCII_UC_OFS = 8'h37;
   localparam logic [7:0] ASCII_LC_OFS = 8'h57;

endpackage

// File: rtl/uart_hex_framer_if.sv
// Request/character handshake between the result source, the framer and uart_tx.
// master = framer side (drives the UART strobe/data and status), slave = surrounding logic.
interface uart_hex_framer_if;

   logic       start;
   logic [7:0] data_in;
   logic       uartbusy;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;
   logic       timeout_err;

   modport master (
      input  start, data_in, uartbusy,
      output tx_en, tx_data, busy, done, timeout_err
   );

   modport slave (
      output start, data_in, uartbusy,
      input  tx_en, tx_data, busy, done, timeout_err
   );

endinterface

// File: rtl/uart_hex_framer_nibble_to_ascii.sv
// Converts one 4-bit value to its ASCII hex digit; UPPERCASE selects 'A'-'F' or 'a'-'f'.
module nibble_to_ascii
   import uart_hex_framer_pkg::*;
#(
   parameter bit UPPERCASE = 1'b1
) (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble <= 4'd9) begin
         ascii = ASCII_0 + {4'h0, nibble};
      end else begin
         ascii = (UPPERCASE ? ASCII_UC_OFS : ASCII_LC_OFS) + {4'h0, nibble};
      end
   end

endmodule

// File: rtl/uart_hex_framer.sv
// Captures a result byte on start and sends it as ASCII hex characters over a tx_en/uartbusy handshake.
// Define FRAMER_CRLF_EN to append CR LF after the two hex digits.
module uart_hex_framer
   import uart_hex_framer_pkg::*;
#(
   parameter bit          UPPERCASE    = 1'b1,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input logic               clk,
   input logic               reset_n,
   uart_hex_framer_if.master bus
);

`ifdef FRAMER_CRLF_EN
   localparam int unsigned IDX_W = 2;
`else
   localparam int unsigned IDX_W = 1;
`endif
   localparam int unsigned      CNT_W    = $clog2(BUSY_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tx_en_q, tx_en_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             terr_q, terr_d;
   logic             advance;
   logic [3:0]       nibble;
   logic [7:0]       hex_char;
   logic [7:0]       next_char;

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tx_en_d = 1'b0;
      done_d  = 1'b0;
      terr_d  = 1'b0;
      advance = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               byte_d  = bus.data_in;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (!bus.uartbusy) begin
               tx_en_d = 1'b1;
               cnt_d   = '0;
               state_d = WAIT_HI;
            end
         end
         WAIT_HI: begin
            // a rise seen on the last counted cycle still beats the timeout
            if (bus.uartbusy) begin
               state_d = WAIT_LO;
            end else if (cnt_q == CNT_LAST) begin
               terr_d  = 1'b1;
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_LO: begin
            if (!bus.uartbusy) advance = 1'b1;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // the last index is all-ones for both frame lengths
      if (advance) begin
         if (&idx_q) begin
            state_d = FINISH;
            done_d  = 1'b1;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEND;
         end
      end
   end

   // Outputs are registered from the next state, so the character is loaded on SEND entry
   // and tx_en appears one cycle after SEND is entered.
   always_comb nibble = idx_d[0] ? byte_d[3:0] : byte_d[7:4];

   nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_nibble_to_ascii (
      .nibble (nibble),
      .ascii  (hex_char)
   );

`ifdef FRAMER_CRLF_EN
   always_comb next_char = idx_d[1] ? (idx_d[0] ? ASCII_LF : ASCII_CR) : hex_char;
`else
   always_comb next_char = hex_char;
`endif

   always_comb begin
      busy_d    = (state_d == SEND) || (state_d == WAIT_HI) || (state_d == WAIT_LO);
      tx_data_d = (state_d == SEND) ? next_char : tx_data_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         byte_q    <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         terr_q    <= terr_d;
      end
   end

   assign bus.tx_en       = tx_en_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = terr_q;

endmodule
